// File: rtl/screen_sequencer.sv
// screen_sequencer: game-level controller that selects the full-screen image
// shown by the VGA top. It arbitrates game events, holds HIT/MISS banners for
// HOLD_CYCLES clocks, and latches win screens until a restart.
//
// Optional build macro: SCREEN_SEQ_FLASH_EN
//   When defined, HIT/MISS banners flash between the banner image and the
//   default board every FLASH_CYCLES clocks. When undefined, the banner is
//   steady and no flash logic is built.
module screen_sequencer #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int FLASH_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       hit_evt,
  input  logic       miss_evt,
  input  logic       p1_win,
  input  logic       p2_win,
  input  logic       restart,
  output logic [5:0] screen,
  output logic       busy
);

  // Hold counter sized to hold HOLD_CYCLES; loads HOLD_CYCLES-1 on banner entry.
  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  // State encoding; any other value recovers to S_START.
  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_HIT   = 3'd2;
  localparam logic [2:0] S_MISS  = 3'd3;
  localparam logic [2:0] S_P1WIN = 3'd4;
  localparam logic [2:0] S_P2WIN = 3'd5;

  // One-hot screen codes understood by the VGA top.
  localparam logic [5:0] SCR_START = 6'd1;
  localparam logic [5:0] SCR_HIT   = 6'd2;
  localparam logic [5:0] SCR_MISS  = 6'd4;
  localparam logic [5:0] SCR_P1WIN = 6'd8;
  localparam logic [5:0] SCR_P2WIN = 6'd16;
  localparam logic [5:0] SCR_PLAY  = 6'd32;

  // Reject parameter values that would make the hold or flash timing meaningless.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("screen_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (FLASH_CYCLES < 1) begin : g_bad_flash
    $error("screen_sequencer: FLASH_CYCLES must be >= 1");
  end

  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [5:0]        screen_q, screen_d;
  logic              busy_q, busy_d;
  logic              banner_load;
  logic              in_banner_d;

  // Next-state arbitration: restart > p1_win > p2_win > hit_evt > miss_evt.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    banner_load = 1'b0;
    case (state_q)
      S_START: begin
        // Only start_btn leaves the start screen; restart is meaningless here.
        if (start_btn) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (restart) begin
          state_d = S_START;
        end else if (p1_win) begin
          state_d = S_P1WIN;
        end else if (p2_win) begin
          state_d = S_P2WIN;
        end else if (hit_evt) begin
          state_d     = S_HIT;
          banner_load = 1'b1;
        end else if (miss_evt) begin
          state_d     = S_MISS;
          banner_load = 1'b1;
        end
      end
      S_HIT, S_MISS: begin
        if (restart) begin
          state_d = S_START;
        end else if (p1_win) begin
          state_d = S_P1WIN;
        end else if (p2_win) begin
          state_d = S_P2WIN;
        end else if (hit_evt) begin
          // Same-type events retrigger; opposite type switches banners.
          state_d     = S_HIT;
          banner_load = 1'b1;
        end else if (miss_evt) begin
          state_d     = S_MISS;
          banner_load = 1'b1;
        end else if (hold_q == '0) begin
          state_d = S_PLAY;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_P1WIN, S_P2WIN: begin
        // Win screens are sticky until restart.
        if (restart) state_d = S_START;
      end
      default: begin
        state_d = S_START;
      end
    endcase

    in_banner_d = (state_d == S_HIT) || (state_d == S_MISS);
    if (banner_load) begin
      hold_d = HOLD_LOAD;
    end else if (!in_banner_d) begin
      // Counter idles at zero whenever no banner is up.
      hold_d = '0;
    end
  end

`ifdef SCREEN_SEQ_FLASH_EN
  localparam int                 FLASH_W   = $clog2(FLASH_CYCLES + 1);
  localparam logic [FLASH_W-1:0] FLASH_TOP = FLASH_W'(FLASH_CYCLES - 1);

  logic [FLASH_W-1:0] flash_q, flash_d;
  logic               phase_q, phase_d;

  // Flash timer: restarts in phase 0 on every banner load, toggles the phase
  // after FLASH_CYCLES banner cycles, and idles at zero outside banners.
  always_comb begin
    flash_d = flash_q;
    phase_d = phase_q;
    if (banner_load || !in_banner_d) begin
      flash_d = '0;
      phase_d = 1'b0;
    end else if (flash_q == FLASH_TOP) begin
      flash_d = '0;
      phase_d = ~phase_q;
    end else begin
      flash_d = flash_q + 1'b1;
    end
  end
`endif

  // Screen decode from the next state, so screen registers alongside state.
  always_comb begin
    case (state_d)
      S_START: screen_d = SCR_START;
      S_PLAY:  screen_d = SCR_PLAY;
      S_HIT:   screen_d = SCR_HIT;
      S_MISS:  screen_d = SCR_MISS;
      S_P1WIN: screen_d = SCR_P1WIN;
      S_P2WIN: screen_d = SCR_P2WIN;
      default: screen_d = SCR_START;
    endcase
`ifdef SCREEN_SEQ_FLASH_EN
    // Phase 1 of a flashing banner shows the default board instead.
    if (in_banner_d && phase_d) screen_d = SCR_PLAY;
`endif
    busy_d = in_banner_d;
  end

  // State, hold counter and registered outputs; reset wins over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_START;
      hold_q   <= '0;
      screen_q <= SCR_START;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      screen_q <= screen_d;
      busy_q   <= busy_d;
    end
  end

`ifdef SCREEN_SEQ_FLASH_EN
  // Flash timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_q <= '0;
      phase_q <= 1'b0;
    end else begin
      flash_q <= flash_d;
      phase_q <= phase_d;
    end
  end
`endif

  assign screen = screen_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: directed scenarios followed by random
// event traffic, checked against an event-level reference model.
module tb_screen_sequencer;

`ifdef SCREEN_SEQ_FLASH_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 4;
`endif
  localparam int FLASH = 2;

  // Event bits: {reset, start_btn, hit, miss, p1_win, p2_win, restart}
  localparam logic [6:0] E_RST  = 7'h40;
  localparam logic [6:0] E_SB   = 7'h20;
  localparam logic [6:0] E_HIT  = 7'h10;
  localparam logic [6:0] E_MISS = 7'h08;
  localparam logic [6:0] E_P1   = 7'h04;
  localparam logic [6:0] E_P2   = 7'h02;
  localparam logic [6:0] E_RS   = 7'h01;
  localparam logic [6:0] E_NONE = 7'h00;

  logic       clk = 1'b0;
  logic       reset, start_btn, hit_evt, miss_evt, p1_win, p2_win, restart;
  logic [5:0] screen;
  logic       busy;

  typedef struct {
    logic [5:0] scr;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: the image currently on screen and how many banner
  // cycles remain before it falls back to the board.
  int m_mode = 1;
  int m_left = 0;

  always #5 clk = ~clk;

  screen_sequencer #(
    .HOLD_CYCLES (HOLD),
    .FLASH_CYCLES(FLASH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start_btn(start_btn),
    .hit_evt  (hit_evt),
    .miss_evt (miss_evt),
    .p1_win   (p1_win),
    .p2_win   (p2_win),
    .restart  (restart),
    .screen   (screen),
    .busy     (busy)
  );

  function automatic void model_step(input logic [6:0] ev);
    if (ev[6]) begin
      m_mode = 1;
      m_left = 0;
    end else if (m_mode == 1) begin
      if (ev[5]) m_mode = 32;
    end else if (m_mode == 8 || m_mode == 16) begin
      if (ev[0]) m_mode = 1;
    end else begin
      // board (32) or a banner (2/4)
      if (ev[0])      m_mode = 1;
      else if (ev[2]) m_mode = 8;
      else if (ev[1]) m_mode = 16;
      else if (ev[4]) begin m_mode = 2; m_left = HOLD; end
      else if (ev[3]) begin m_mode = 4; m_left = HOLD; end
      else if (m_mode == 2 || m_mode == 4) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 32;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.busy = (m_mode == 2 || m_mode == 4);
    e.scr  = 6'(m_mode);
`ifdef SCREEN_SEQ_FLASH_EN
    if (e.busy && (((HOLD - m_left) / FLASH) % 2 == 1)) e.scr = 6'd32;
`endif
    return e;
  endfunction

  // Present one cycle of inputs, record what the DUT must show after the
  // coming edge, then step past that edge.
  task automatic drive(input logic [6:0] ev);
    {reset, start_btn, hit_evt, miss_evt, p1_win, p2_win, restart} = ev;
    model_step(ev);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(E_NONE);
  endtask

  // Monitor: the DUT presents a registered screen every cycle.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (screen !== e.scr) begin
          bad++;
          $display("FAIL screen cyc=%0d got=%0d want=%0d", cyc, screen, e.scr);
        end
        total++;
        if (busy !== e.busy) begin
          bad++;
          $display("FAIL busy cyc=%0d got=%0b want=%0b", cyc, busy, e.busy);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [6:0] ev;
    int r;
    // Reset and idle; events other than start_btn ignored in START.
    drive(E_RST);
    drive(E_RST);
    idle(10);
    drive(E_HIT);
    drive(E_RS);
    drive(E_P1);
    idle(2);
    // Start, then a full HIT banner.
    drive(E_SB);
    idle(2);
    drive(E_HIT);
    idle(HOLD + 2);
    // MISS arriving at hold count 1 reloads the banner.
    drive(E_HIT);
    idle(HOLD - 2);
    drive(E_MISS);
    idle(HOLD + 2);
    // Same-type retrigger.
    drive(E_MISS);
    idle(1);
    drive(E_MISS);
    idle(HOLD + 1);
    // Simultaneous wins plus hit: P1 wins and sticks.
    drive(E_P1 | E_P2 | E_HIT);
    idle(1);
    drive(E_P2);
    drive(E_HIT);
    drive(E_SB);
    drive(E_MISS);
    drive(E_RS);
    idle(1);
    // Reset in the middle of a MISS banner.
    drive(E_SB);
    drive(E_MISS);
    idle(1);
    drive(E_RST);
    idle(1);
    drive(E_SB);
    idle(2);
    // P2 win, then win and restart during a banner.
    drive(E_P2 | E_HIT);
    drive(E_P1);
    drive(E_RS);
    drive(E_SB);
    drive(E_HIT);
    drive(E_P2);
    drive(E_RS);
    drive(E_SB);
    drive(E_MISS);
    drive(E_RS | E_P1);
    idle(2);
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 99);
      ev = E_NONE;
      if (r < 1)       ev = E_RST;
      else if (r < 6)  ev = E_SB;
      else if (r < 14) ev = E_HIT;
      else if (r < 20) ev = E_MISS;
      else if (r < 22) ev = E_P1;
      else if (r < 24) ev = E_P2;
      else if (r < 28) ev = E_RS;
      if ($urandom_range(0, 19) == 0) ev = ev | 7'(1 << $urandom_range(0, 5));
      drive(ev);
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
